// File: rtl/bf16_pkg.sv
// bf16_pkg: bfloat16 field layout, NaN test, result record and checker states
package bf16_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ERROR_WIDTH = 2;
  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 7;
  localparam int MANT_MSB = 6;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic [DATA_WIDTH-1:0] out;
    logic [ERROR_WIDTH-1:0] error;
  } res_rec_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    return (&v[EXP_MSB:EXP_LSB]) && (|v[MANT_MSB:0]);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered full/empty and flush
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp, wp_n, rp_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr, rd;
  assign wr = push && !full && !flush;
  assign rd = pop && !empty && !flush;
  assign wp_n = flush ? '0 : wr ? wp + 1'b1 : wp;
  assign rp_n = flush ? '0 : rd ? rp + 1'b1 : rp;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
      full <= (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
      empty <= wp_n == rp_n;
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/fp_mul_result_checker.sv
// fp_mul_result_checker: pairs buffered multiplier results with golden entries and scores them
module fp_mul_result_checker
  import bf16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NUM_VECTORS = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [DATA_WIDTH-1:0]  res_in1,
  input  logic [DATA_WIDTH-1:0]  res_in2,
  input  logic [DATA_WIDTH-1:0]  res_out,
  input  logic [ERROR_WIDTH-1:0] res_error,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [DATA_WIDTH-1:0]  exp_out,
  input  logic [ERROR_WIDTH-1:0] exp_error,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_WIDTH-1:0]   pass_cnt,
  output logic [CNT_WIDTH-1:0]   mismatch_cnt,
  output logic                   fail_valid,
  output logic [CNT_WIDTH-1:0]   fail_index,
  output logic [DATA_WIDTH-1:0]  fail_in1,
  output logic [DATA_WIDTH-1:0]  fail_in2,
  output logic [DATA_WIDTH-1:0]  fail_out,
  output logic [DATA_WIDTH-1:0]  fail_exp
);
  state_t state, state_n;
  res_rec_t head, wrec;
  logic full, empty, cmp, match, last;
  logic [CNT_WIDTH:0] total;
  assign wrec = '{in1: res_in1, in2: res_in2, out: res_out, error: res_error};
  assign res_ready = (state == RUN) && !full;
  assign cmp = (state == RUN) && !empty && exp_valid;
  assign exp_ready = cmp;
  assign match = (head.error == exp_error) &&
                 ((head.out == exp_out) || (is_nan(head.out) && is_nan(exp_out)));
  assign total = {1'b0, pass_cnt} + {1'b0, mismatch_cnt} + (CNT_WIDTH+1)'(1);
  assign last = cmp && !start && (total >= (CNT_WIDTH+1)'(NUM_VECTORS));
  sync_fifo #(.WIDTH($bits(res_rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(start), .push(res_valid && res_ready), .pop(cmp),
    .wdata(wrec), .rdata(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = start ? RUN : last ? DONE : state;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
    pass = done && (mismatch_cnt == '0);
  end
  // start clears the scoreboard and overrides any compare in the same cycle
  always_ff @(posedge clk) begin
    if (rst || start) begin
      pass_cnt <= '0;
      mismatch_cnt <= '0;
      fail_valid <= 1'b0;
      fail_index <= '0;
      fail_in1 <= '0;
      fail_in2 <= '0;
      fail_out <= '0;
      fail_exp <= '0;
    end else if (cmp) begin
      if (match) pass_cnt <= pass_cnt + CNT_WIDTH'(pass_cnt != '1);
      else begin
        mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(mismatch_cnt != '1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_index <= pass_cnt + mismatch_cnt;
          fail_in1 <= head.in1;
          fail_in2 <= head.in2;
          fail_out <= head.out;
          fail_exp <= exp_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_result_checker.sv
// tb_fp_mul_result_checker: directed checks of the bfloat16 result checker
module tb_fp_mul_result_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic res_valid = 1'b0, exp_valid = 1'b0;
  logic [15:0] res_in1 = '0, res_in2 = '0, res_out = '0, exp_out = '0;
  logic [1:0] res_error = '0, exp_error = '0;
  logic res_ready, exp_ready, busy, done, pass, fail_valid;
  logic [15:0] pass_cnt, mismatch_cnt, fail_index, fail_in1, fail_in2, fail_out, fail_exp;
  int errors = 0, checks = 0;

  fp_mul_result_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .res_valid(res_valid), .res_ready(res_ready), .res_in1(res_in1), .res_in2(res_in2),
    .res_out(res_out), .res_error(res_error),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_out(exp_out), .exp_error(exp_error),
    .busy(busy), .done(done), .pass(pass), .pass_cnt(pass_cnt), .mismatch_cnt(mismatch_cnt),
    .fail_valid(fail_valid), .fail_index(fail_index), .fail_in1(fail_in1), .fail_in2(fail_in2),
    .fail_out(fail_out), .fail_exp(fail_exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic push_res(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] o, input logic [1:0] e);
    int n = 0;
    res_valid = 1'b1; res_in1 = a; res_in2 = b; res_out = o; res_error = e;
    #1;
    while (!res_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    if (n == 100) chk("res_timeout", 32'd0, 32'd1);
    cyc(1);
    res_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] o, input logic [1:0] e);
    int n = 0;
    exp_valid = 1'b1; exp_out = o; exp_error = e;
    #1;
    while (!exp_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    if (n == 100) chk("exp_timeout", 32'd0, 32'd1);
    cyc(1);
    exp_valid = 1'b0;
  endtask

  task automatic vec(input logic [15:0] d_out, input logic [1:0] d_err,
                     input logic [15:0] g_out, input logic [1:0] g_err);
    push_res(16'h3F80, 16'h4000, d_out, d_err);
    push_exp(g_out, g_err);
  endtask

  initial begin
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_mismatch_cnt", mismatch_cnt, 0);
    chk("rst_fail_valid", fail_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_exp_ready", exp_ready, 0);
    rst = 1'b0;
    cyc(1);
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_res_ready", res_ready, 1);

    for (int i = 0; i < 10; i++) vec(16'h4000, 2'd0, 16'h4000, 2'd0);
    chk("all_match_done", done, 1);
    chk("all_match_pass", pass, 1);
    chk("all_match_pass_cnt", pass_cnt, 10);
    chk("all_match_mismatch_cnt", mismatch_cnt, 0);
    chk("done_res_ready", res_ready, 0);

    pulse_start();
    chk("restart_pass_cnt", pass_cnt, 0);
    for (int i = 0; i < 10; i++) vec(i == 4 ? 16'h4001 : 16'h4000, 2'd0, 16'h4000, 2'd0);
    chk("v4_done", done, 1);
    chk("v4_pass", pass, 0);
    chk("v4_mismatch_cnt", mismatch_cnt, 1);
    chk("v4_pass_cnt", pass_cnt, 9);
    chk("v4_fail_valid", fail_valid, 1);
    chk("v4_fail_index", fail_index, 4);
    chk("v4_fail_out", fail_out, 16'h4001);
    chk("v4_fail_exp", fail_exp, 16'h4000);
    chk("v4_fail_in1", fail_in1, 16'h3F80);
    chk("v4_fail_in2", fail_in2, 16'h4000);

    pulse_start();
    for (int i = 0; i < 8; i++) push_res(16'h3F80, 16'h4000, 16'h4000 + 16'(i), 2'd0);
    chk("full_res_ready", res_ready, 0);
    cyc(12);
    chk("holdoff_res_ready", res_ready, 0);
    chk("holdoff_pass_cnt", pass_cnt, 0);
    for (int i = 0; i < 8; i++) push_exp(16'h4000 + 16'(i), 2'd0);
    chk("drain_pass_cnt", pass_cnt, 8);
    chk("drain_res_ready", res_ready, 1);
    vec(16'h4000, 2'd0, 16'h4000, 2'd0);
    vec(16'h4000, 2'd0, 16'h4000, 2'd0);
    chk("holdoff_done", done, 1);
    chk("holdoff_pass", pass, 1);
    chk("holdoff_final_cnt", pass_cnt, 10);

    pulse_start();
    vec(16'h7FC1, 2'd0, 16'h7FC0, 2'd0);
    chk("nan_pass_cnt", pass_cnt, 1);
    vec(16'h8000, 2'd0, 16'h0000, 2'd0);
    chk("zero_mismatch_cnt", mismatch_cnt, 1);
    chk("zero_fail_index", fail_index, 1);
    chk("zero_fail_out", fail_out, 16'h8000);
    chk("zero_fail_exp", fail_exp, 16'h0000);
    vec(16'h4000, 2'd1, 16'h4000, 2'd0);
    chk("err_mismatch_cnt", mismatch_cnt, 2);
    chk("err_keeps_index", fail_index, 1);
    for (int i = 0; i < 7; i++) vec(16'h4000, 2'd0, 16'h4000, 2'd0);
    chk("mixed_done", done, 1);
    chk("mixed_pass", pass, 0);
    chk("mixed_pass_cnt", pass_cnt, 8);

    pulse_start();
    vec(16'h4000, 2'd0, 16'h3F80, 2'd0);
    for (int i = 0; i < 4; i++) vec(16'h4000, 2'd0, 16'h4000, 2'd0);
    chk("pre_restart_pass_cnt", pass_cnt, 4);
    chk("pre_restart_fail_valid", fail_valid, 1);
    push_res(16'h3F80, 16'h4000, 16'h4000, 2'd0);
    pulse_start();
    chk("restart_busy", busy, 1);
    chk("restart_pass_cnt0", pass_cnt, 0);
    chk("restart_mismatch_cnt0", mismatch_cnt, 0);
    chk("restart_fail_valid", fail_valid, 0);
    exp_valid = 1'b1;
    #1;
    chk("restart_fifo_empty", exp_ready, 0);
    exp_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 10; i++) vec(16'h4000, 2'd0, 16'h4000, 2'd0);
    chk("restart_done", done, 1);
    chk("restart_pass", pass, 1);
    chk("restart_final_cnt", pass_cnt, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
